// File: rtl/pipe_fwd_ctrl_if.sv
// Bundle of ID-stage signals exchanged with the operand-forwarding and
// load-use interlock unit. The master side is the pipeline (ID stage plus
// the stage result taps); the slave side is pipe_fwd_ctrl.
interface pipe_fwd_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  logic                     pipe_en;
  logic                     flush;
  logic                     issue_valid;
  logic                     issue_wen;
  logic [REG_AW-1:0]        issue_addr;
  logic                     issue_load;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*REG_AW-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data_rf;
  logic [DEPTH*XLEN-1:0]    stage_data;
  logic [NUM_RD*XLEN-1:0]   rd_data_fwd;
  logic [NUM_RD-1:0]        fwd_hit;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output pipe_en, flush, issue_valid, issue_wen, issue_addr, issue_load,
           rd_en, rd_addr, rd_data_rf, stage_data,
    input  rd_data_fwd, fwd_hit, stall, stall_cnt
  );

  modport slave (
    input  pipe_en, flush, issue_valid, issue_wen, issue_addr, issue_load,
           rd_en, rd_addr, rd_data_rf, stage_data,
    output rd_data_fwd, fwd_hit, stall, stall_cnt
  );
endinterface

// File: rtl/pipe_fwd_ctrl.sv
// Operand-forwarding and load-use interlock unit.
// A DEPTH-entry shift scoreboard follows every in-flight register write from
// EXE (entry 0) down to WB (entry DEPTH-1). Each ID read port takes the
// youngest in-flight producer of its source register; if that producer is a
// load whose data is not yet available the unit requests a stall. An older
// ready producer is never used in place of an unready younger one, since it
// would deliver a stale value.
module pipe_fwd_ctrl #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_fwd_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Scoreboard: one {vld, addr, load} triple per tracked stage.
  logic [DEPTH-1:0]             vld_r;
  logic [DEPTH-1:0][REG_AW-1:0] addr_r;
  logic [DEPTH-1:0]             load_r;
  logic [CNT_W-1:0]             cnt_r;

  logic                         entry_vld_s;
  logic                         stall_s;
  logic [NUM_RD-1:0]            hit_s;
  logic [NUM_RD-1:0]            unready_s;
  logic [NUM_RD*XLEN-1:0]       fwd_data_s;

  // Per-port search scratch, rewritten for every port in turn.
  logic                         cand_s;
  logic                         found_s;
  logic                         rdy_s;
  logic [XLEN-1:0]              sel_data_s;

  // A squashed or stalled ID instruction enters EXE as a bubble.
  assign entry_vld_s = bus.issue_valid & bus.issue_wen & ~stall_s & ~bus.flush;

  // A stall needs a live, unflushed instruction that actually uses an unready operand.
  assign stall_s = bus.issue_valid & ~bus.flush & (|(bus.rd_en & unready_s));

  // Youngest-producer search and operand mux for every read port.
  always_comb begin
    hit_s      = '0;
    unready_s  = '0;
    fwd_data_s = bus.rd_data_rf;
    cand_s     = 1'b0;
    found_s    = 1'b0;
    rdy_s      = 1'b0;
    sel_data_s = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      found_s    = 1'b0;
      rdy_s      = 1'b0;
      sel_data_s = '0;
      // Walk oldest to youngest so the youngest candidate is the one left standing.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        cand_s     = vld_r[k] && (addr_r[k] != '0) &&
                     (addr_r[k] == bus.rd_addr[p*REG_AW +: REG_AW]);
        found_s    = found_s | cand_s;
        rdy_s      = cand_s ? (!load_r[k] || (k >= LOAD_LAT)) : rdy_s;
        sel_data_s = cand_s ? bus.stage_data[k*XLEN +: XLEN] : sel_data_s;
      end
      if (found_s && rdy_s) begin
        fwd_data_s[p*XLEN +: XLEN] = sel_data_s;
        hit_s[p]                   = 1'b1;
        unready_s[p]               = 1'b0;
      end else if (found_s) begin
        hit_s[p]     = 1'b0;
        unready_s[p] = 1'b1;
      end else begin
        hit_s[p]     = 1'b0;
        unready_s[p] = 1'b0;
      end
    end
  end

  // Scoreboard shift: advance with the pipeline, oldest entry retires into the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r  <= '0;
      addr_r <= '0;
      load_r <= '0;
    end else if (bus.pipe_en) begin
      vld_r  <= {vld_r[DEPTH-2:0], entry_vld_s};
      addr_r <= {addr_r[DEPTH-2:0], bus.issue_addr};
      load_r <= {load_r[DEPTH-2:0], bus.issue_load};
    end
  end

  // Saturating count of cycles in which the pipeline advanced under a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (bus.pipe_en && stall_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bus.rd_data_fwd = fwd_data_s;
  assign bus.fwd_hit     = hit_s;
  assign bus.stall       = stall_s;
  assign bus.stall_cnt   = cnt_r;

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed bench for pipe_fwd_ctrl: forwarding, priority, load-use stall,
// $0 and disabled ports, freeze, flush, async reset and counter saturation.
// A 4-bit stall counter keeps the saturation case short.
module tb_pipe_fwd_ctrl;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int CW     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_fwd_ctrl_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD),
                     .DEPTH(DEPTH), .CNT_W(CW)) bus ();

  pipe_fwd_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD), .DEPTH(DEPTH),
                  .LOAD_LAT(1), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.pipe_en     = 1'b1;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_wen   = 1'b0;
    bus.issue_addr  = '0;
    bus.issue_load  = 1'b0;
    bus.rd_en       = '0;
    bus.rd_addr     = '0;
    bus.rd_data_rf  = '0;
    bus.stage_data  = '0;
  endtask

  task automatic issue(input logic [4:0] a, input logic ld);
    bus.issue_valid = 1'b1;
    bus.issue_wen   = 1'b1;
    bus.issue_addr  = a;
    bus.issue_load  = ld;
    bus.rd_en       = '0;
  endtask

  initial begin
    set_idle();

    // 1. Reset state
    #3;
    bus.rd_addr    = {5'd0, 5'd5};
    bus.rd_data_rf = {32'h0, 32'h11};
    #1;
    chk("rst_fwd0", bus.rd_data_fwd[31:0], 32'h11);
    chk("rst_hit", 32'(bus.fwd_hit), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 2. ALU -> ALU forwarding
    set_idle();
    issue(5'd3, 1'b0);
    #1;
    chk("alu_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_wen   = 1'b1;
    bus.issue_addr  = 5'd3;
    bus.issue_load  = 1'b0;
    bus.rd_en       = 2'b11;
    bus.rd_addr     = {5'd9, 5'd3};
    bus.rd_data_rf  = {32'h99, 32'h5555};
    bus.stage_data  = {32'h0, 32'h0, 32'hAAAA};
    #1;
    chk("alu_fwd0", bus.rd_data_fwd[31:0], 32'hAAAA);
    chk("alu_fwd1_rf", bus.rd_data_fwd[63:32], 32'h99);
    chk("alu_hit", 32'(bus.fwd_hit), 32'd1);
    chk("alu_stall", 32'(bus.stall), 32'd0);
    tick();

    // 3. Priority: youngest producer wins
    bus.issue_valid = 1'b0;
    bus.issue_wen   = 1'b0;
    bus.rd_addr     = {5'd3, 5'd3};
    bus.stage_data  = {32'h3, 32'h2, 32'h1};
    #1;
    chk("prio_ex_mem", bus.rd_data_fwd[31:0], 32'h1);
    tick();
    #1;
    chk("prio_mem_wb0", bus.rd_data_fwd[31:0], 32'h2);
    chk("prio_mem_wb1", bus.rd_data_fwd[63:32], 32'h2);
    chk("prio_hit", 32'(bus.fwd_hit), 32'd3);
    set_idle();
    tick(); tick(); tick();

    // 4. Load-use: stall exactly one cycle, bubble, then forward from MEM
    issue(5'd4, 1'b1);
    #1;
    chk("lu_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_wen   = 1'b1;
    bus.issue_addr  = 5'd8;
    bus.issue_load  = 1'b0;
    bus.rd_en       = 2'b11;
    bus.rd_addr     = {5'd4, 5'd8};
    bus.rd_data_rf  = {32'h44, 32'h88};
    bus.stage_data  = {32'h0, 32'hBEEF, 32'hDEAD};
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_hit1_wait", 32'(bus.fwd_hit[1]), 32'd0);
    tick();
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("lu_stall_drop", 32'(bus.stall), 32'd0);
    chk("lu_fwd1", bus.rd_data_fwd[63:32], 32'hBEEF);
    chk("lu_bubble_hit", 32'(bus.fwd_hit), 32'd2);
    chk("lu_bubble_fwd0", bus.rd_data_fwd[31:0], 32'h88);
    set_idle();
    tick(); tick(); tick();

    // 5a. Register $0 never matches, even as a load
    issue(5'd0, 1'b1);
    tick();
    bus.issue_wen   = 1'b0;
    bus.rd_en       = 2'b11;
    bus.rd_addr     = {5'd0, 5'd0};
    bus.rd_data_rf  = '0;
    bus.stage_data  = {32'h0, 32'h0, 32'h1234};
    #1;
    chk("r0_hit", 32'(bus.fwd_hit), 32'd0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    chk("r0_fwd0", bus.rd_data_fwd[31:0], 32'h0);
    set_idle();
    tick(); tick(); tick();

    // 5b. Load to $7 read on disabled ports; older ALU $6 forwarded on port 1
    issue(5'd6, 1'b0);
    tick();
    issue(5'd7, 1'b1);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_wen   = 1'b0;
    bus.issue_load  = 1'b0;
    bus.rd_en       = 2'b00;
    bus.rd_addr     = {5'd6, 5'd7};
    bus.rd_data_rf  = {32'h61, 32'h71};
    bus.stage_data  = {32'h2222, 32'h6666, 32'h7777};
    #1;
    chk("dis_stall", 32'(bus.stall), 32'd0);
    chk("dis_hit", 32'(bus.fwd_hit), 32'd2);
    chk("dis_fwd1", bus.rd_data_fwd[63:32], 32'h6666);
    bus.rd_en = 2'b01;
    #1;
    chk("en_stall", 32'(bus.stall), 32'd1);

    // 6a. Freeze during a load-use stall: scoreboard and counter hold
    bus.pipe_en = 1'b0;
    tick();
    tick();
    chk("frz_stall", 32'(bus.stall), 32'd1);
    chk("frz_fwd1", bus.rd_data_fwd[63:32], 32'h6666);
    chk("frz_hit", 32'(bus.fwd_hit), 32'd2);
    chk("frz_cnt", 32'(bus.stall_cnt), 32'd1);

    // 6b. Flush beats stall
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("unflush_stall", 32'(bus.stall), 32'd1);

    // 6c. Async reset mid-stall
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_hit", 32'(bus.fwd_hit), 32'd0);
    chk("arst_fwd1", bus.rd_data_fwd[63:32], 32'h61);
    chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    tick();

    // 6d. Counter saturation at all-ones
    for (int i = 0; i < 15; i++) begin
      issue(5'd4, 1'b1);
      tick();
      bus.issue_wen = 1'b0;
      bus.rd_en     = 2'b01;
      bus.rd_addr   = {5'd0, 5'd4};
      tick();
    end
    chk("sat_cnt15", 32'(bus.stall_cnt), 32'd15);
    issue(5'd4, 1'b1);
    tick();
    bus.issue_wen = 1'b0;
    bus.rd_en     = 2'b01;
    bus.rd_addr   = {5'd0, 5'd4};
    #1;
    chk("sat_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("sat_nowrap", 32'(bus.stall_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
